// File: rtl/alu_operand_stage_if.sv
// Operand-stage bus: instruction input, writeback return and ALU-operand output channels.
// Latency: none (signal bundle only).
// Backpressure: valid/ready on the instruction and operand channels; writeback is never stalled.
interface alu_operand_stage_if #(
    parameter int CNT_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic              wb_en;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_a;
    logic [31:0]       out_b;
    logic [2:0]        out_funct3;
    logic [6:0]        out_funct7;
    logic [4:0]        out_rd;
    logic [CNT_W-1:0]  illegal_cnt;

    // Upstream fetch/writeback/ALU side that talks to the stage
    modport master (
        output in_valid, in_instr, wb_en, wb_rd, wb_data, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_funct3, out_funct7, out_rd, illegal_cnt
    );

    // The operand stage itself
    modport slave (
        input  in_valid, in_instr, wb_en, wb_rd, wb_data, out_ready,
        output in_ready, out_valid, out_a, out_b, out_funct3, out_funct7, out_rd, illegal_cnt
    );
endinterface

// File: rtl/alu_operand_stage.sv
// RV32I OP/OP-IMM decode + register read, registered into a one-entry ALU operand stage.
// Latency: 1 cycle from accepted instruction to out_valid; writeback bypass is same-cycle.
// Backpressure: in_ready drops while the output is held (out_ready=0) or on an unresolved RAW hazard.
module alu_operand_stage #(
    parameter int NREGS = 32,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_operand_stage_if.slave io_bus
);
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    logic [31:0]      r_regs [0:NREGS-1];
    logic [NREGS-1:0] r_pending;
    logic             r_out_valid;
    logic [31:0]      r_out_a;
    logic [31:0]      r_out_b;
    logic [2:0]       r_out_funct3;
    logic [6:0]       r_out_funct7;
    logic [4:0]       r_out_rd;
    logic [CNT_W-1:0] r_illegal_cnt;

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [2:0]  w_funct3;
    logic        w_is_op;
    logic        w_is_opimm;
    logic        w_legal;
    logic        w_wb_wr;
    logic        w_fwd1;
    logic        w_fwd2;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic [31:0] w_b;
    logic [6:0]  w_funct7;
    logic        w_hazard;
    logic        w_in_ready;
    logic        w_xfer;
    logic        w_legal_xfer;
    logic        w_illegal_xfer;

    assign w_opcode   = io_bus.in_instr[6:0];
    assign w_rd       = io_bus.in_instr[11:7];
    assign w_funct3   = io_bus.in_instr[14:12];
    assign w_rs1      = io_bus.in_instr[19:15];
    assign w_rs2      = io_bus.in_instr[24:20];
    assign w_is_op    = (w_opcode == OPC_OP);
    assign w_is_opimm = (w_opcode == OPC_OPIMM);
    assign w_legal    = w_is_op || w_is_opimm;

    // A writeback to x0 is a no-op for the regfile, the bypass and the scoreboard alike
    assign w_wb_wr = io_bus.wb_en && (io_bus.wb_rd != 5'd0);
    assign w_fwd1  = w_wb_wr && (io_bus.wb_rd == w_rs1);
    assign w_fwd2  = w_wb_wr && (io_bus.wb_rd == w_rs2);

    // Source operand read: x0 reads zero, same-cycle writeback wins over the stale regfile copy
    always_comb begin
        w_rs1_val = r_regs[w_rs1];
        w_rs2_val = r_regs[w_rs2];
        if (w_rs1 == 5'd0) begin
            w_rs1_val = 32'd0;
        end else if (w_fwd1) begin
            w_rs1_val = io_bus.wb_data;
        end
        if (w_rs2 == 5'd0) begin
            w_rs2_val = 32'd0;
        end else if (w_fwd2) begin
            w_rs2_val = io_bus.wb_data;
        end
    end

    // Operand B and funct7 selection; shift-immediates keep funct7 to tell SRLI from SRAI
    always_comb begin
        w_b      = w_rs2_val;
        w_funct7 = io_bus.in_instr[31:25];
        if (w_is_opimm) begin
            w_b = {{20{io_bus.in_instr[31]}}, io_bus.in_instr[31:20]};
            if ((w_funct3 != 3'b001) && (w_funct3 != 3'b101)) begin
                w_funct7 = 7'd0;
            end
        end
    end

    // RAW hazard: a pending source not rescued by this cycle's writeback; rs2 only matters for OP
    always_comb begin
        w_hazard = 1'b0;
        if (io_bus.in_valid && w_legal) begin
            if ((w_rs1 != 5'd0) && r_pending[w_rs1] && !w_fwd1) begin
                w_hazard = 1'b1;
            end
            if (w_is_op && (w_rs2 != 5'd0) && r_pending[w_rs2] && !w_fwd2) begin
                w_hazard = 1'b1;
            end
        end
    end

    assign w_in_ready     = (!r_out_valid || io_bus.out_ready) && !w_hazard;
    assign w_xfer         = io_bus.in_valid && w_in_ready;
    assign w_legal_xfer   = w_xfer && w_legal;
    assign w_illegal_xfer = w_xfer && !w_legal;

    // Architectural register file; x0 is never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (w_wb_wr) begin
            r_regs[io_bus.wb_rd] <= io_bus.wb_data;
        end
    end

    // Pending-producer scoreboard; a new producer beats a same-cycle writeback to the same reg
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (w_legal_xfer && (w_rd == 5'(i))) begin
                    r_pending[i] <= 1'b1;
                end else if (w_wb_wr && (io_bus.wb_rd == 5'(i))) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    // One-entry output register: load on legal transfer, drain on out_ready, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_a      <= 32'd0;
            r_out_b      <= 32'd0;
            r_out_funct3 <= 3'd0;
            r_out_funct7 <= 7'd0;
            r_out_rd     <= 5'd0;
        end else if (w_legal_xfer) begin
            r_out_valid  <= 1'b1;
            r_out_a      <= w_rs1_val;
            r_out_b      <= w_b;
            r_out_funct3 <= w_funct3;
            r_out_funct7 <= w_funct7;
            r_out_rd     <= w_rd;
        end else if (io_bus.out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    // Saturating count of accepted-and-dropped non-ALU instructions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal_cnt <= '0;
        end else if (w_illegal_xfer && (r_illegal_cnt != '1)) begin
            r_illegal_cnt <= r_illegal_cnt + 1'b1;
        end
    end

    assign io_bus.in_ready    = w_in_ready;
    assign io_bus.out_valid   = r_out_valid;
    assign io_bus.out_a       = r_out_a;
    assign io_bus.out_b       = r_out_b;
    assign io_bus.out_funct3  = r_out_funct3;
    assign io_bus.out_funct7  = r_out_funct7;
    assign io_bus.out_rd      = r_out_rd;
    assign io_bus.illegal_cnt = r_illegal_cnt;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: vector table plus hand sequences for hazard, backpressure, illegal, reset.
// Expected ALU operations queue up at issue and are popped when the stage presents them.
// Outputs sampled on the falling edge; inputs driven 1 time unit after the rising edge.
module tb_alu_operand_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_operand_stage_if #(.CNT_W(8)) bus();

    alu_operand_stage #(.NREGS(32), .CNT_W(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus.slave)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        exp_t        e;
    } vec_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pa, input logic [31:0] pb,
                                input logic [2:0] pf3, input logic [6:0] pf7, input logic [4:0] prd);
        exp_t e;
        e.a = pa; e.b = pb; e.f3 = pf3; e.f7 = pf7; e.rd = prd;
        return e;
    endfunction

    // Scoreboard: every consumed operation must match the oldest expected entry
    always @(negedge clk) begin
        exp_t act;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            act = mk(bus.out_a, bus.out_b, bus.out_funct3, bus.out_funct7, bus.out_rd);
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual_rd=%0d required=none", bus.out_rd);
            end else begin
                check("alu_op", act, sb_q.pop_front());
            end
        end
    end

    task automatic issue(input logic [31:0] instr, output int waits);
        waits = 0;
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        @(negedge clk);
        while (!bus.in_ready && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout instr=%h actual=stalled required=accepted", instr);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] data);
        bus.wb_en   = 1'b1;
        bus.wb_rd   = rd;
        bus.wb_data = data;
        @(posedge clk);
        #1;
        bus.wb_en = 1'b0;
    endtask

    task automatic drain_check(input string name);
        repeat (3) @(posedge clk);
        #1;
        check(name, sb_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int   w;

        vecs[0] = '{32'h002081B3, mk(32'd5, 32'd3,          3'd0, 7'h00, 5'd3)};   // ADD  x3,x1,x2
        vecs[1] = '{32'hFFF08213, mk(32'd5, 32'hFFFFFFFF,   3'd0, 7'h00, 5'd4)};   // ADDI x4,x1,-1
        vecs[2] = '{32'h4020D293, mk(32'd5, 32'h00000402,   3'd5, 7'h20, 5'd5)};   // SRAI x5,x1,2
        vecs[3] = '{32'h40110433, mk(32'd3, 32'd5,          3'd0, 7'h20, 5'd8)};   // SUB  x8,x2,x1
        vecs[4] = '{32'h80014493, mk(32'd3, 32'hFFFFF800,   3'd4, 7'h00, 5'd9)};   // XORI x9,x2,-2048
        vecs[5] = '{32'h00311513, mk(32'd3, 32'd3,          3'd1, 7'h00, 5'd10)};  // SLLI x10,x2,3

        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'd0;
        bus.wb_en     = 1'b0;
        bus.wb_rd     = 5'd0;
        bus.wb_data   = 32'd0;
        bus.out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_fields", {bus.out_a, bus.out_b, bus.out_funct3, bus.out_funct7, bus.out_rd}, 0);
        check("rst_illegal_cnt", bus.illegal_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        wb(5'd1, 32'd5);
        wb(5'd2, 32'd3);

        // Back-to-back table vectors: must never stall with out_ready high
        for (int i = 0; i < 6; i++) begin
            sb_q.push_back(vecs[i].e);
            issue(vecs[i].instr, w);
            check("no_stall", w, 0);
        end
        drain_check("drain_table");

        // RAW hazard on x3, resolved by the writeback-cycle bypass
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00318333;   // ADD x6,x3,x3
        repeat (2) begin
            @(negedge clk);
            check("hazard_stall", bus.in_ready, 0);
        end
        @(posedge clk);
        #1;
        bus.wb_en   = 1'b1;
        bus.wb_rd   = 5'd3;
        bus.wb_data = 32'd8;
        sb_q.push_back(mk(32'd8, 32'd8, 3'd0, 7'h00, 5'd6));
        @(negedge clk);
        check("bypass_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.wb_en    = 1'b0;
        sb_q.push_back(mk(32'd8, 32'd0, 3'd0, 7'h00, 5'd12));
        issue(32'h00018633, w);        // ADD x12,x3,x0
        check("pending_cleared", w, 0);
        drain_check("drain_hazard");

        // Backpressure: first op holds while second waits, then both flow in order
        bus.out_ready = 1'b0;
        sb_q.push_back(mk(32'd5, 32'd1, 3'd0, 7'h00, 5'd13));
        issue(32'h00108693, w);        // ADDI x13,x1,1
        sb_q.push_back(mk(32'd3, 32'd2, 3'd0, 7'h00, 5'd14));
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00210713;   // ADDI x14,x2,2
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_hold", {bus.out_valid, bus.out_a, bus.out_b, bus.out_rd}, {1'b1, 32'd5, 32'd1, 5'd13});
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        drain_check("drain_backpressure");

        // Illegal opcodes: accepted without stall, dropped, counted
        for (int i = 0; i < 3; i++) begin
            issue(32'h00000073, w);
            check("illegal_no_stall", w, 0);
            #3;
            check("illegal_no_output", bus.out_valid, 0);
        end
        check("illegal_cnt3", bus.illegal_cnt, 3);

        // x0 ignores writes and reads as zero
        wb(5'd0, 32'd7);
        sb_q.push_back(mk(32'd0, 32'd0, 3'd0, 7'h00, 5'd7));
        issue(32'h000003B3, w);        // ADD x7,x0,x0
        check("x0_no_stall", w, 0);
        drain_check("drain_x0");

        // Counter saturates at all-ones
        for (int i = 0; i < 255; i++) begin
            issue(32'h00000073, w);
        end
        check("illegal_sat", bus.illegal_cnt, 8'hFF);

        // Reset while an operation is held clears it and every pending bit
        bus.out_ready = 1'b0;
        issue(32'h002087B3, w);        // ADD x15,x1,x2 (discarded by reset)
        #2;
        check("held_before_reset", bus.out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_fields", {bus.out_a, bus.out_b, bus.out_rd}, 0);
        check("midrst_illegal_cnt", bus.illegal_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        sb_q.push_back(mk(32'd0, 32'd0, 3'd0, 7'h00, 5'd16));
        issue(32'h00078833, w);        // ADD x16,x15,x0
        check("reset_clears_pending", w, 0);
        drain_check("drain_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
Decode/operand stage directly upstream of the combinational ALU in the RV32I core. It accepts RV32I OP and OP-IMM instructions through a valid/ready handshake and reads rs1/rs2 from an internal 32x32 register file. It builds the ALU operands A and B and the funct3/funct7 controls, and registers them into a one-entry output stage that drives the ALU inputs. ALU results return through a writeback port. A per-register pending scoreboard stalls read-after-write hazards, and a same-cycle writeback bypass resolves them early.

Parameters:
NREGS, 32, architectural register count; x0 is hardwired to zero.
CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  in_instr is valid
in_ready  output  1  stage accepts in_instr this cycle
in_instr  input  32  RV32I instruction word
wb_en  input  1  write wb_data to register wb_rd
wb_rd  input  5  writeback destination
wb_data  input  32  writeback value (ALU Result)
out_valid  output  1  out_* fields hold a valid ALU operation
out_ready  input  1  downstream consumes the operation this cycle
out_a  output  32  ALU operand A (rs1 value)
out_b  output  32  ALU operand B (rs2 value or sign-extended immediate)
out_funct3  output  3  ALU funct3
out_funct7  output  7  ALU funct7
out_rd  output  5  destination register carried with the operation
illegal_cnt  output  CNT_W  count of dropped non-ALU instructions

Behaviour:
- Reset, asynchronous on rst_n low:
  - All registers x0..x31 = 0; all pending bits = 0.
  - out_valid = 0; out_a, out_b, out_rd, out_funct3, out_funct7 = 0; illegal_cnt = 0.
  - Reset mid-operation discards the held operation and all pending state.
- Decode is based on opcode = in_instr[6:0].
  - 0110011 (OP): B = regfile[rs2]; funct7 = in_instr[31:25].
  - 0010011 (OP-IMM): B = sign-extended in_instr[31:20].
    - funct3 = 001 or 101: funct7 = in_instr[31:25].
    - Any other funct3: funct7 = 0000000.
  - In both cases: A = regfile[rs1]; funct3 = in_instr[14:12]; rd = in_instr[11:7].
  - Any other opcode is illegal. The instruction is accepted and dropped. No output is produced. illegal_cnt increments and saturates at all-ones.
- Register read rules:
  - x0 always reads 0.
  - If wb_en=1 and wb_rd equals a source register (and is not 0) in the same cycle, wb_data is forwarded.
- Register write rule: when wb_en=1 and wb_rd != 0, the write takes effect on the clock edge. Writes to x0 are ignored.
- Hazard: an instruction with in_valid=1 is blocked when rs1 or rs2 (B from rs2 only for OP) is nonzero, pending, and not forwarded this cycle. Illegal instructions never stall.
- Handshake:
  - in_ready = (!out_valid || out_ready) && !hazard.
  - A transfer occurs when in_valid && in_ready. A legal transfer loads the out_* registers and sets out_valid=1 on the next edge, giving 1-cycle latency.
  - When out_valid && out_ready and no new legal transfer occurs, out_valid clears.
  - While out_valid && !out_ready, all out_* fields hold stable.
  - in_ready may depend combinationally on in_instr (hazard check).
- Scoreboard:
  - A legal transfer with rd != 0 sets pending[rd].
  - wb_en with wb_rd != 0 clears pending[wb_rd].
  - If both events target the same register in the same cycle, set wins (the newer producer).
- Throughput: 1 operation per cycle with out_ready held high and no hazards.

Test Plan:
1. Reset; wb x1=5, then wb x2=3; issue 0x002081B3 (ADD x3,x1,x2) → next cycle out_valid=1, out_a=5, out_b=3, out_funct3=000, out_funct7=0000000, out_rd=3.
2. Issue 0xFFF08213 (ADDI x4,x1,-1) → out_a=5, out_b=0xFFFFFFFF, funct3=000, funct7=0. Issue 0x4020D293 (SRAI x5,x1,2) → out_b=0x00000402, funct3=101, funct7=0100000.
3. Hazard: issue ADD x3,x1,x2, then 0x00318333 (ADD x6,x3,x3) → in_ready=0 until the wb_en cycle with wb_rd=3, wb_data=8. ADD x6 is accepted in that cycle with out_a=out_b=8 via bypass.
4. Backpressure: hold out_ready=0 with two legal instructions queued → first stays on out_* unchanged and in_ready=0. Raise out_ready → second appears the next cycle with no loss or duplication.
5. Illegal: issue 0x00000073 three times → in_ready=1, out_valid stays 0, illegal_cnt=3. x0: wb rd=0 data=7, then ADD x7,x0,x0 → out_a=0, out_b=0. Assert rst_n low while out_valid=1 → out_valid=0 immediately and all pending bits cleared.
